// File: rtl/parity_correction_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_correction_sequencer_pkg
// Description : Shared state encoding, status codes and geometry constants
//               for the 16x8 two-dimensional parity correction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_correction_sequencer_pkg;

  localparam int ROWS      = 16;
  localparam int COLS      = 8;
  localparam int HALF_ROWS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ANALYZE   = 3'd1,
    ISSUE_TOP = 3'd2,
    ISSUE_BOT = 3'd3,
    DONE      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_CLEAN   = 2'b00,
    ST_CORR    = 2'b01,
    ST_UNCORR  = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

endpackage
`default_nettype wire

// File: rtl/parity_correction_sequencer_classifier.sv
`default_nettype none
// ============================================================================
// Module      : parity_half_classifier
// Description : Combinational classification of one 8-row half of the parity
//               block: clean (no mismatches), single (exactly one row and one
//               column mismatch) and the indices of the failing bit.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_half_classifier
  import parity_correction_sequencer_pkg::*;
(
  input  logic [HALF_ROWS-1:0] rows,
  input  logic [COLS-1:0]      cols,
  output logic                 clean,
  output logic                 single,
  output logic [2:0]           row_idx,
  output logic [2:0]           col_idx
);

  // Popcount-based classification; indices are only meaningful when single=1
  always_comb begin
    clean   = (rows == '0) && (cols == '0);
    single  = ($countones(rows) == 1) && ($countones(cols) == 1);
    row_idx = 3'd0;
    col_idx = 3'd0;
    for (int i = 0; i < HALF_ROWS; i++) begin
      if (rows[i]) row_idx = 3'(i);
    end
    for (int j = 0; j < COLS; j++) begin
      if (cols[j]) col_idx = 3'(j);
    end
  end

endmodule
`default_nettype wire

// File: rtl/parity_correction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : parity_correction_sequencer
// Description : Captures row/top/bottom parity mismatch vectors, classifies
//               each half, issues up to two bit-flip commands over a
//               valid/ready handshake and reports a completion status.
//               Optional event counters: define PARITY_SEQ_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_correction_sequencer
  import parity_correction_sequencer_pkg::*;
#(
  parameter int FLIP_TIMEOUT = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [COLS-1:0]  top_errors,
  input  logic [COLS-1:0]  bottom_errors,
  input  logic [ROWS-1:0]  row_errors,
  output logic             busy,
  output logic             flip_valid,
  output logic [3:0]       flip_row,
  output logic [2:0]       flip_col,
  input  logic             flip_ready,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] corrected_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  // The wait counter only needs to reach FLIP_TIMEOUT-1: the cycle that would
  // make it FLIP_TIMEOUT is the one that aborts.
  localparam int             TO_W      = (FLIP_TIMEOUT > 1) ? $clog2(FLIP_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'((FLIP_TIMEOUT > 0) ? FLIP_TIMEOUT - 1 : 0);

  state_t          state_q, state_d;
  status_t         status_q, status_d;
  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] top_q, top_d;
  logic [COLS-1:0] bot_q, bot_d;
  logic [TO_W-1:0] wait_q, wait_d;

  logic       top_clean, top_single, bot_clean, bot_single;
  logic [2:0] top_row, top_col, bot_row, bot_col;
  logic       top_bad, bot_bad, to_hit;

  parity_half_classifier u_top (
    .rows    (row_q[HALF_ROWS-1:0]),
    .cols    (top_q),
    .clean   (top_clean),
    .single  (top_single),
    .row_idx (top_row),
    .col_idx (top_col)
  );

  parity_half_classifier u_bot (
    .rows    (row_q[ROWS-1:HALF_ROWS]),
    .cols    (bot_q),
    .clean   (bot_clean),
    .single  (bot_single),
    .row_idx (bot_row),
    .col_idx (bot_col)
  );

  assign top_bad = !top_clean && !top_single;
  assign bot_bad = !bot_clean && !bot_single;
  assign to_hit  = (FLIP_TIMEOUT != 0) && (wait_q == C_TO_LAST);

  // Next-state, vector capture, wait counting and status update
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    row_d    = row_q;
    top_d    = top_q;
    bot_d    = bot_q;
    wait_d   = wait_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = row_errors;
          top_d   = top_errors;
          bot_d   = bottom_errors;
          state_d = ANALYZE;
        end
      end
      ANALYZE: begin
        if (top_bad || bot_bad) begin
          state_d  = DONE;
          status_d = ST_UNCORR;
        end else if (top_clean && bot_clean) begin
          state_d  = DONE;
          status_d = ST_CLEAN;
        end else begin
          wait_d  = '0;
          state_d = top_single ? ISSUE_TOP : ISSUE_BOT;
        end
      end
      ISSUE_TOP: begin
        if (flip_ready) begin
          if (bot_single) begin
            wait_d  = '0;
            state_d = ISSUE_BOT;
          end else begin
            state_d  = DONE;
            status_d = ST_CORR;
          end
        end else if (to_hit) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end else if (FLIP_TIMEOUT != 0) begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      ISSUE_BOT: begin
        if (flip_ready) begin
          state_d  = DONE;
          status_d = ST_CORR;
        end else if (to_hit) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end else if (FLIP_TIMEOUT != 0) begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-vector registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      status_q <= ST_CLEAN;
      row_q    <= '0;
      top_q    <= '0;
      bot_q    <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      row_q    <= row_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      wait_q   <= wait_d;
    end
  end

  // Flip command decoded from the issuing state; bottom rows are offset by 8
  always_comb begin
    flip_valid = 1'b0;
    flip_row   = 4'd0;
    flip_col   = 3'd0;
    case (state_q)
      ISSUE_TOP: begin
        flip_valid = 1'b1;
        flip_row   = {1'b0, top_row};
        flip_col   = top_col;
      end
      ISSUE_BOT: begin
        flip_valid = 1'b1;
        flip_row   = {1'b1, bot_row};
        flip_col   = bot_col;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign status = status_q;

`ifdef PARITY_SEQ_COUNTERS_EN
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] unc_cnt_q, unc_cnt_d;

  // Saturating job counters, stepped in the DONE cycle from the fresh status
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    unc_cnt_d  = unc_cnt_q;
    if (state_q == DONE) begin
      if (status_q == ST_CORR && corr_cnt_q != '1)
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if ((status_q == ST_UNCORR || status_q == ST_TIMEOUT) && unc_cnt_q != '1)
        unc_cnt_d = unc_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
    end
  end

  assign corrected_cnt = corr_cnt_q;
  assign uncorr_cnt    = unc_cnt_q;
`else
  assign corrected_cnt = '0;
  assign uncorr_cnt    = '0;
`endif

endmodule
`default_nettype wire
